// File: rtl/register_file_pkg.sv
// Shared constants and the register word type for the register file.
// Optional write-through forwarding is enabled with the REGFILE_WRITE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_COUNT      = 2 ** ADDR_WIDTH_DEF;
    localparam int ZERO_REG       = 0;

    typedef logic [DATA_WIDTH_DEF-1:0] reg_word_t;

endpackage

// File: rtl/register_file_if.sv
// Decode-stage register file bus: two read ports and one write port.
// The master side drives addresses and write data; the slave returns read data.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    modport master (
        output write_en,
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  write_en,
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        output read_data1,
        output read_data2
    );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: array mux with hardwired-zero register 0.
// With REGFILE_WRITE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
`endif
    output logic [DATA_WIDTH-1:0] rd_data
);

    always_comb begin
        rd_data = '0;
        if (rd_addr != ADDR_WIDTH'(ZERO_REG)) begin
            rd_data = regs[rd_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
            // Forwarding is suppressed under reset: that edge discards the write.
            if (!reset && wr_en && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: 2 async read ports, 1 sync write port, r0 reads as zero.
// Optional same-cycle write forwarding: define REGFILE_WRITE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    register_file_if.slave  rf
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (rf.write_en && (rf.write_reg != ADDR_WIDTH'(ZERO_REG))) begin
            regs_d[rf.write_reg] = rf.write_data;
        end
    end

    // Reset wins over any write presented at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .rd_addr (rf.read_reg1),
        .regs    (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .reset   (reset),
        .wr_en   (rf.write_en),
        .wr_addr (rf.write_reg),
        .wr_data (rf.write_data),
`endif
        .rd_data (rf.read_data1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port2 (
        .rd_addr (rf.read_reg2),
        .regs    (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .reset   (reset),
        .wr_en   (rf.write_en),
        .wr_addr (rf.write_reg),
        .wr_data (rf.write_data),
`endif
        .rd_data (rf.read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus randomized traffic
// against an array model of the register contents.
module tb_register_file;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;

    int vec_cnt = 0;
    int err_cnt = 0;

    reg_word_t model [REG_COUNT];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic reg_word_t exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!reset && rf.write_en && rf.write_reg == addr) return rf.write_data;
`endif
        return model[addr];
    endfunction

    // Advance one clock edge and apply the architectural effect to the model.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
        end else if (rf.write_en && rf.write_reg != 5'd0) begin
            model[rf.write_reg] = rf.write_data;
        end
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        chk({tag, "_p1"}, rf.read_data1, exp_read(rf.read_reg1));
        chk({tag, "_p2"}, rf.read_data2, exp_read(rf.read_reg2));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < REG_COUNT; i++) begin
            rf.read_reg1 = 5'(i);
            rf.read_reg2 = 5'(REG_COUNT - 1 - i);
            check_reads(tag);
        end
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        rf.write_en   = en;
        rf.write_reg  = a;
        rf.write_data = d;
    endtask

    initial begin
        for (int i = 0; i < REG_COUNT; i++) model[i] = 32'hDEAD_BEEF;
        reset = 1'b1;
        wr(1'b0, 5'd0, '0);
        rf.read_reg1 = 5'd0;
        rf.read_reg2 = 5'd1;
        #2;
        chk("r0_in_reset", rf.read_data1, 32'h0);
        cycle();
        reset = 1'b0;

        rf.read_reg1 = 5'd0;  rf.read_reg2 = 5'd1;
        #1;
        chk("rst_r0", rf.read_data1, 32'h0);
        chk("rst_r1", rf.read_data2, 32'h0);
        rf.read_reg1 = 5'd31;
        #1;
        chk("rst_r31", rf.read_data1, 32'h0);
        sweep("rst_all");

        wr(1'b1, 5'd1, 32'hAAAA_AAAA);
        cycle();
        wr(1'b1, 5'd2, 32'hCCCC_CCCC);
        cycle();
        wr(1'b0, 5'd2, 32'h0);
        rf.read_reg1 = 5'd1;  rf.read_reg2 = 5'd2;
        #1;
        chk("r1_val", rf.read_data1, 32'hAAAA_AAAA);
        chk("r2_val", rf.read_data2, 32'hCCCC_CCCC);

        rf.read_reg1 = 5'd0;  rf.read_reg2 = 5'd3;
        #1;
        chk("r0_zero", rf.read_data1, 32'h0);
        chk("r3_unwritten", rf.read_data2, 32'h0);

        wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        rf.read_reg1 = 5'd0;
        #1;
        chk("r0_during_wr", rf.read_data1, 32'h0);
        cycle();
        wr(1'b0, 5'd0, 32'h0);
        rf.read_reg1 = 5'd0;
        #1;
        chk("r0_after_wr", rf.read_data1, 32'h0);
        sweep("after_r0_wr");

        wr(1'b0, 5'd1, 32'h1234_5678);
        cycle();
        rf.read_reg1 = 5'd1;
        #1;
        chk("r1_no_we", rf.read_data1, 32'hAAAA_AAAA);

        wr(1'b1, 5'd5, 32'h1111_1111);
        cycle();
        wr(1'b1, 5'd5, 32'h5A5A_5A5A);
        rf.read_reg1 = 5'd5;  rf.read_reg2 = 5'd5;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("rdw_before_p1", rf.read_data1, 32'h5A5A_5A5A);
        chk("rdw_before_p2", rf.read_data2, 32'h5A5A_5A5A);
`else
        chk("rdw_before_p1", rf.read_data1, 32'h1111_1111);
        chk("rdw_before_p2", rf.read_data2, 32'h1111_1111);
`endif
        cycle();
        wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("rdw_after", rf.read_data1, 32'h5A5A_5A5A);

        wr(1'b1, 5'd7, 32'h7777_7777);
        cycle();
        reset = 1'b1;
        wr(1'b1, 5'd7, 32'h0BAD_0BAD);
        rf.read_reg1 = 5'd7;  rf.read_reg2 = 5'd0;
        #1;
        chk("r7_pre_reset", rf.read_data1, 32'h7777_7777);
        chk("r0_rst_wr", rf.read_data2, 32'h0);
        cycle();
        reset = 1'b0;
        wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("r7_post_reset", rf.read_data1, 32'h0);
        sweep("post_reset");

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            wr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom());
            rf.read_reg1 = ($urandom_range(0, 3) == 0) ? rf.write_reg : 5'($urandom_range(0, 31));
            rf.read_reg2 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            check_reads("rand");
            cycle();
        end
        reset = 1'b0;
        wr(1'b0, 5'd0, 32'h0);
        sweep("final");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
